// File: rtl/matrix_rm_driver.sv
// Static-side byte-stream driver for the reconfigurable 2x2 matrix partition:
// loads A and B operands, waits for the RM to settle, then streams Res back out.
module matrix_rm_driver #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rm_a,
  output logic [31:0] rm_b,
  input  logic [31:0] rm_res,
  input  logic        rm_decouple,
  output logic        busy
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    SEND   = 2'd3
  } state_t;

  localparam logic [3:0] SCNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_idx;
  logic [3:0]  r_scnt;
  logic [31:0] r_rmA;
  logic [31:0] r_rmB;
  logic [31:0] r_res;

  logic        w_load;
  logic        w_inXfer;
  logic        w_outXfer;
  logic        w_lastByte;
  logic        w_settleDone;
  logic [4:0]  w_lane;

  // Byte 0 is the most significant lane, so lane offset is (3 - idx) * 8.
  assign w_lane       = {~r_idx, 3'b000};
  assign w_load       = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_lastByte   = (r_idx == 2'd3);
  assign w_inXfer     = in_ready && in_valid;
  assign w_outXfer    = out_valid && out_ready;
  assign w_settleDone = (r_state == SETTLE) && !rm_decouple && (r_scnt == SCNT_LAST);

  assign in_ready  = w_load && !rst;
  assign out_valid = (r_state == SEND);
  assign out_data  = out_valid ? r_res[w_lane +: 8] : 8'h00;
  assign rm_a      = r_rmA;
  assign rm_b      = r_rmB;
  assign busy      = (r_state != LOAD_A) || (r_idx != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_A: if (w_inXfer && w_lastByte) w_next = LOAD_B;
      LOAD_B: if (w_inXfer && w_lastByte) w_next = SETTLE;
      SETTLE: if (w_settleDone) w_next = SEND;
      SEND:   if (w_outXfer && w_lastByte) w_next = LOAD_A;
      default: w_next = LOAD_A;
    endcase
  end

  // idx wraps 3 -> 0 naturally, which is the clear at the end of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_scnt <= 4'd0;
      r_rmA  <= 32'h0;
      r_rmB  <= 32'h0;
      r_res  <= 32'h0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_inXfer) begin
            r_rmA[w_lane +: 8] <= in_data;
            r_idx              <= r_idx + 2'd1;
          end
        end
        LOAD_B: begin
          if (w_inXfer) begin
            r_rmB[w_lane +: 8] <= in_data;
            r_idx              <= r_idx + 2'd1;
            if (w_lastByte) r_scnt <= 4'd0;
          end
        end
        SETTLE: begin
          if (rm_decouple) begin
            r_scnt <= 4'd0;
          end else if (r_scnt == SCNT_LAST) begin
            r_res <= rm_res;
            r_idx <= 2'd0;
          end else begin
            r_scnt <= r_scnt + 4'd1;
          end
        end
        SEND: begin
          if (w_outXfer) r_idx <= r_idx + 2'd1;
        end
        default: r_idx <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_rm_driver.sv
// Self-checking bench for matrix_rm_driver: directed scenarios plus randomized
// transactions, checked against a bytewise-add reference of the sent operands.
module tb_matrix_rm_driver;

  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rm_a;
  logic [31:0] rm_b;
  logic [31:0] rm_res;
  logic        rm_decouple;
  logic        busy;

  logic [7:0]  ops [8];
  int          passCount = 0;
  int          checkCount = 0;

  matrix_rm_driver #(.SETTLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rm_a       (rm_a),
    .rm_b       (rm_b),
    .rm_res     (rm_res),
    .rm_decouple(rm_decouple),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The loaded RM is an adder; while decoupled its output is garbage.
  function automatic logic [31:0] rmAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
    return r;
  endfunction

  assign rm_res = rm_decouple ? 32'hDEAD_BEEF : rmAdd(rm_a, rm_b);

  function automatic logic [31:0] expectedRes();
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r = {r[23:0], 8'(ops[i] + ops[i+4])};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
  endtask

  // gapMode: 0 = back-to-back, 1 = 3-cycle gap before byte 3, 2 = random gaps.
  task automatic applyStimulus(input int gapMode, input int decoupleCycles);
    int k;
    int guard;
    int gapCount;
    int n;
    bit acc;
    k = 0;
    guard = 0;
    gapCount = 0;
    while (k < 8 && guard < 200) begin
      if (gapMode == 1 && k == 3 && gapCount < 3) begin
        in_valid = 1'b0;
        gapCount++;
      end else if (gapMode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1;
      end
      if (gapMode == 2) rm_decouple = 1'($urandom_range(0, 1));
      in_data = ops[k];
      checkOutput("in_ready_load", 32'(in_ready), 32'd1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    if (k < 8) checkOutput("load_timeout", 32'(k), 32'd8);
    in_valid = 1'b0;
    in_data  = 8'h00;
    rm_decouple = (decoupleCycles > 0);
    checkOutput("busy_settle", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      checkOutput("in_ready_settle", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
      if (n >= decoupleCycles) rm_decouple = 1'b0;
    end
    rm_decouple = 1'b0;
    checkOutput("settle_latency", 32'(n), 32'(decoupleCycles + SC));
  endtask

  // readyMode: 0 = always ready, 1 = toggle every other cycle, 2 = random.
  task automatic receiveResult(input logic [31:0] exp, input int nBytes,
                               input int readyMode, input bit noise);
    int k;
    int c;
    bit acc;
    k = 0;
    c = 0;
    checkOutput("rm_a_send", rm_a, {ops[0], ops[1], ops[2], ops[3]});
    checkOutput("rm_b_send", rm_b, {ops[4], ops[5], ops[6], ops[7]});
    while (k < nBytes && c < 100) begin
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) rm_decouple = 1'($urandom_range(0, 1));
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      checkOutput("out_data", 32'(out_data), 32'(exp[(3-k)*8 +: 8]));
      checkOutput("in_ready_send", 32'(in_ready), 32'd0);
      acc = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) k++;
      c++;
    end
    if (k < nBytes) checkOutput("send_timeout", 32'(k), 32'(nBytes));
    out_ready   = 1'b1;
    rm_decouple = 1'b0;
    if (nBytes == 4) begin
      checkOutput("out_valid_done", 32'(out_valid), 32'd0);
      checkOutput("busy_done", 32'(busy), 32'd0);
      checkOutput("in_ready_done", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic setOps(input logic [63:0] v);
    for (int i = 0; i < 8; i++) ops[i] = v[(7-i)*8 +: 8];
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rm_decouple = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rm_a", rm_a, 32'd0);
    checkOutput("rst_rm_b", rm_b, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] basic add");
    setOps(64'h01020304_10203040);
    applyStimulus(0, 0);
    receiveResult(32'h11223344, 4, 0, 1'b0);

    $display("[TB] wrap-around");
    setOps(64'hFF807F00_01808100);
    applyStimulus(0, 0);
    checkOutput("wrap_rm_a", rm_a, 32'hFF807F00);
    checkOutput("wrap_rm_b", rm_b, 32'h01808100);
    receiveResult(32'h00000000, 4, 0, 1'b0);

    $display("[TB] backpressure and gaps");
    setOps(64'h01020304_10203040);
    applyStimulus(1, 0);
    receiveResult(32'h11223344, 4, 1, 1'b0);

    $display("[TB] decouple in settle");
    setOps(64'h0A0B0C0D_01010101);
    applyStimulus(0, 5);
    receiveResult(32'h0B0C0D0E, 4, 0, 1'b0);

    $display("[TB] reset mid-send");
    setOps(64'h11111111_22222222);
    applyStimulus(0, 0);
    receiveResult(32'h33333333, 2, 0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_rm_a", rm_a, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    setOps(64'h05050505_01010101);
    applyStimulus(0, 0);
    receiveResult(32'h06060606, 4, 0, 1'b0);

    $display("[TB] back-to-back and randomized transactions");
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
      applyStimulus(t < 2 ? 0 : int'($urandom_range(0, 2)),
                    t < 2 ? 0 : int'($urandom_range(0, 4)));
      receiveResult(expectedRes(), 4, t < 2 ? 0 : int'($urandom_range(0, 2)), t >= 2);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/matrix_rm_driver.md
# matrix_rm_driver

Static-side driver for the reconfigurable 2x2 matrix partition. It assembles two packed 32-bit operand matrices from an 8-bit valid/ready input stream and drives them onto the partition's `A`/`B` inputs. It then waits a fixed settle interval, captures the partition's 32-bit `Res`, and streams the four result bytes back out. It sits between the host byte link and whichever reconfigurable module (RM) is loaded, such as addition or multiplication, and is agnostic to the RM's arithmetic.

## Interface
- `SETTLE_CYCLES`, default 2: cycles allowed for the RM combinational path after the last operand byte. Legal range is 1..15.
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_data`, input, 8: operand byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the driver accepts a byte this cycle.
- `out_data`, output, 8: result byte.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: the sink accepts a byte this cycle.
- `rm_a`, output, 32: packed matrix A to the RM, laid out as {A00,A01,A10,A11} with A00 in bits [31:24].
- `rm_b`, output, 32: packed matrix B to the RM, same layout.
- `rm_res`, input, 32: packed result from the RM, same layout.
- `rm_decouple`, input, 1: high while the partition is being reconfigured, meaning `rm_res` is invalid.
- `busy`, output, 1: a transaction is in progress.

## Operation
- **Transfers.** An input transfer occurs when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- **Input byte order.** Bytes 0-3 are A00, A01, A10, A11. Bytes 4-7 are B00, B01, B10, B11. Each byte is written into its lane of `rm_a`/`rm_b` on the accepting edge.
- **Output byte order.** Res00 first (`rm_res[31:24]`), then Res01, Res10, Res11.
- **State machine.** States are LOAD_A, LOAD_B, SETTLE, SEND. A 2-bit byte index `idx` and a 4-bit settle counter `scnt` support them.
  - **LOAD_A:** `in_ready`=1. Each transfer writes `rm_a` lane `idx` and increments `idx`. The transfer at `idx`=3 clears `idx` and goes to LOAD_B.
  - **LOAD_B:** same as LOAD_A, but writes `rm_b`. The transfer at `idx`=3 clears `scnt` and goes to SETTLE.
  - **SETTLE:** `in_ready`=0.
    - If `rm_decouple`=1, `scnt` is held at 0.
    - Otherwise `scnt` increments.
    - When `scnt`=SETTLE_CYCLES-1 and `rm_decouple`=0, `rm_res` is captured into the result register, `idx` is cleared, and the state goes to SEND.
  - **SEND:** `out_valid`=1 and `out_data` = result byte `idx`. Each transfer increments `idx`. The transfer at `idx`=3 clears `idx` and goes to LOAD_A.
- **Operand hold.** `rm_a`/`rm_b` hold their values from the last write until overwritten by the next transaction. They are never cleared between transactions.
- **Result stability.** The result register is stable throughout SEND. Changes on `rm_res` or `rm_decouple` during SEND have no effect.
- **`busy`.** `busy` = (state != LOAD_A) | (`idx` != 0).
- **Arithmetic.** No arithmetic is performed in this block; result bytes are passed through exactly as the RM produces them.

## Timing
- **Reset values.** While `rst` is high:
  - state = LOAD_A, `idx` = 0, `scnt` = 0;
  - `rm_a` = 0, `rm_b` = 0, result register = 0;
  - `out_valid` = 0, `out_data` = 0, `busy` = 0;
  - `in_ready` is forced to 0.
- **After reset.** `in_ready`=1 on the first cycle after `rst` deasserts.
- **Reset mid-transaction.** Assertion at any point aborts the transaction immediately. No partial result is emitted, and the next transaction starts at byte 0.
- **Registered outputs.** `in_ready`, `out_valid` and `out_data` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- **Throughput.** Input accepts one byte per cycle when `in_valid` is held high, so 8 operand bytes take 8 cycles minimum. Output emits one byte per cycle when `out_ready` is held high.
- **Latency.** With `rm_decouple` low, `out_valid` rises exactly SETTLE_CYCLES edges after the edge that accepts byte 7. Each cycle `rm_decouple` is high during SETTLE restarts the settle count.
- **Backpressure.** `in_valid` low stalls LOAD without losing position. `out_ready` low holds `out_data`/`out_valid` stable.
- **No overlap.** `in_ready`=0 throughout SETTLE and SEND, so the next transaction's bytes are not accepted until the cycle after the 4th result byte transfers.
- **Decouple during load.** `rm_decouple` is ignored in LOAD_A/LOAD_B.

## Test plan
- **Basic add.** Reset, then stream 01 02 03 04 10 20 30 40 back-to-back, with the bench modelling an add RM and `out_ready`=1. Required: out bytes 11 22 33 44, `out_valid` rising SETTLE_CYCLES edges after byte 7, and `busy` low after the 4th byte.
- **Wrap-around.** A = FF 80 7F 00, B = 01 80 81 00 with the add RM. Required: out bytes 00 00 00 00, and `rm_a`=32'hFF807F00, `rm_b`=32'h01808100 during SEND.
- **Backpressure and gaps.** Drop `in_valid` for 3 cycles between bytes 2 and 3, and toggle `out_ready` every other cycle. Required: same result as the basic-add scenario, `out_data` stable while `out_ready`=0, and no duplicated or dropped bytes.
- **Decouple in SETTLE.** With SETTLE_CYCLES=2, assert `rm_decouple` for 5 cycles starting the cycle after byte 7, with the bench's `rm_res` reading X then valid. Required: `out_valid` rises 2 edges after `rm_decouple` falls, and the captured value is the post-decouple `rm_res`.
- **Reset mid-send.** Assert `rst` after 2 result bytes transfer, then run a fresh transaction 05 05 05 05 01 01 01 01. Required: outputs return to their reset values immediately, and the next results are 06 06 06 06.
- **Back-to-back transactions.** Run two transactions consecutively. Required: `in_ready` is 0 until the cycle after the 4th out byte of the first, and the second result reflects only the second operands.
